// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_pkg
// Purpose  : Shared types and helpers for the 2-input AND-gate self-test
//            sequencer: FSM state encoding, vector-count constants and the
//            golden-model function for the gate under test.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package gate_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int         NUM_VEC  = 4;
  localparam logic [1:0] LAST_VEC = 2'(NUM_VEC - 1);

  // Golden model of the gate under test.
  function automatic logic expected_y(input logic a, input logic b);
    return a & b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gate_bist_ctrl
// Purpose  : Self-test sequencer for a 2-input AND gate. On start it walks
//            the vectors 00,01,10,11 onto the gate, holds each for
//            SETTLE_CYCLES, samples gate_y once per vector and reports
//            done / pass / err_count / fail_vec.
// Build    : define GATE_BIST_FAILCAP_EN to build the first-mismatch capture
//            register; otherwise fail_vec is tied to 2'b00.
// Ports    : clk        in   rising-edge clock
//            rst_n      in   asynchronous active-low reset
//            start      in   run request, sampled only in IDLE
//            gate_y     in   output of the gate under test
//            gate_a/b   out  registered gate inputs
//            busy       out  run in progress (accept through last CHECK)
//            done       out  one-cycle end-of-run pulse
//            pass       out  last run had zero mismatches (held)
//            err_count  out  mismatch count of last run, 0..4 (held)
//            fail_vec   out  {a,b} of first mismatching vector
// Revision : 1.0  initial release
// ============================================================================
module gate_bist_ctrl
  import gate_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

  state_t     state;
  logic [3:0] settle_cnt;
  logic [1:0] vec;
  logic       mismatch;

  // The vector register drives the gate directly, so gate_a/gate_b are flops.
  assign gate_a   = vec[1];
  assign gate_b   = vec[0];
  assign mismatch = (gate_y != expected_y(vec[1], vec[0]));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= 4'd0;
      vec        <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec        <= 2'b00;
            err_count  <= 3'd0;
            pass       <= 1'b0;
            settle_cnt <= SETTLE_LOAD;
            busy       <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Counter is loaded with SETTLE_CYCLES and leaves on the edge where
          // it reads 1, giving exactly SETTLE_CYCLES cycles in this state.
          if (settle_cnt <= 4'd1) begin
            state <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 3'd1;
          end
          if (vec == LAST_VEC) begin
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            vec        <= vec + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          // err_count already includes any mismatch from the final CHECK.
          done  <= 1'b1;
          pass  <= (err_count == 3'd0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef GATE_BIST_FAILCAP_EN
  logic [1:0] fail_vec_q;

  // err_count still reads zero on the edge of the first mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec_q <= 2'b00;
    end else if (state == ST_IDLE && start) begin
      fail_vec_q <= 2'b00;
    end else if (state == ST_CHECK && mismatch && err_count == 3'd0) begin
      fail_vec_q <= vec;
    end
  end

  assign fail_vec = fail_vec_q;
`else
  assign fail_vec = 2'b00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gate_bist_ctrl
// Purpose  : Self-checking bench for gate_bist_ctrl. A table of gate models
//            (AND, stuck-1, OR, stuck-0) with hand-computed results is run in
//            a loop, followed by protocol sequences: start re-pulsed mid-run,
//            start held high, and asynchronous reset mid-run.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_gate_bist_ctrl;

  localparam int S        = 2;
  localparam int VEC_LEN  = S + 1;
  localparam int DONE_CYC = 4 * VEC_LEN + 1;  // 13

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       gate_y;
  logic       gate_a, gate_b, busy, done, pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;

  int mode = 0;  // 0 AND, 1 stuck-1, 2 OR, 3 stuck-0
  int checks = 0;
  int failures = 0;

  gate_bist_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .gate_y    (gate_y),
    .gate_a    (gate_a),
    .gate_b    (gate_b),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_vec  (fail_vec)
  );

  always #5 clk = ~clk;

  // Gate under test as seen by the sequencer.
  always_comb begin
    gate_y = gate_a & gate_b;
    case (mode)
      1:       gate_y = 1'b1;
      2:       gate_y = gate_a | gate_b;
      3:       gate_y = 1'b0;
      default: gate_y = gate_a & gate_b;
    endcase
  end

  typedef struct {
    int    mode;
    int    exp_err;
    int    exp_pass;
    int    exp_fv;
    string name;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int exp_vec(input int cyc);
    int v;
    v = cyc / VEC_LEN;
    if (v > 3) v = 3;
    return v;
  endfunction

  // One full run from a start pulse; checks the vector walk, busy, done
  // timing and the final result registers.
  task automatic run_one(input int m, input int e_err, input int e_pass,
                         input int e_fv, input string tag);
    int cyc;
    int done_cyc;
    int bad_vec;
    int bad_busy;
    mode = m;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    cyc      = 0;
    done_cyc = -1;
    bad_vec  = 0;
    bad_busy = 0;
    if ({gate_a, gate_b} !== 2'b00) bad_vec++;
    while (done_cyc < 0 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc <= 4 * VEC_LEN && int'({gate_a, gate_b}) != exp_vec(cyc)) bad_vec++;
      if (cyc >= 1 && cyc < 4 * VEC_LEN && busy !== 1'b1) bad_busy++;
      if (done === 1'b1) done_cyc = cyc;
    end
    chk({tag, "_done_cycle"}, done_cyc, DONE_CYC);
    chk({tag, "_vector_walk_errs"}, bad_vec, 0);
    chk({tag, "_busy_errs"}, bad_busy, 0);
    chk({tag, "_err_count"}, int'(err_count), e_err);
    chk({tag, "_pass"}, int'(pass), e_pass);
    chk({tag, "_fail_vec"}, int'(fail_vec), e_fv);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_hold_vec_11"}, int'({gate_a, gate_b}), 3);
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, int'(done), 0);
  endtask

  initial begin
    int done_cnt;
    int dc[3];
    int vec_at_rst;
    int busy_at_rst;

`ifdef GATE_BIST_FAILCAP_EN
    tbl[0] = '{0, 0, 1, 0, "and"};
    tbl[1] = '{1, 3, 0, 0, "stuck1"};
    tbl[2] = '{2, 2, 0, 1, "or"};
    tbl[3] = '{3, 1, 0, 3, "stuck0"};
`else
    tbl[0] = '{0, 0, 1, 0, "and"};
    tbl[1] = '{1, 3, 0, 0, "stuck1"};
    tbl[2] = '{2, 2, 0, 0, "or"};
    tbl[3] = '{3, 1, 0, 0, "stuck0"};
`endif

    // Reset state.
    #12;
    chk("reset_outputs",
        int'({gate_a, gate_b, busy, done, pass, err_count, fail_vec}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      run_one(tbl[i].mode, tbl[i].exp_err, tbl[i].exp_pass, tbl[i].exp_fv,
              tbl[i].name);
    end

    // start re-pulsed at cycle 5 of a run must be ignored.
    mode = 0;
    done_cnt = 0;
    dc[0] = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 5) start = 1'b1;
      @(posedge clk);
      #1;
      if (n == 5) start = 1'b0;
      if (done === 1'b1) begin
        if (done_cnt == 0) dc[0] = n;
        done_cnt++;
      end
    end
    chk("midrun_start_done_pulses", done_cnt, 1);
    chk("midrun_start_done_cycle", dc[0], DONE_CYC);

    // start held high: runs repeat every 4*(S+1)+2 cycles.
    done_cnt = 0;
    dc[0] = -1; dc[1] = -1; dc[2] = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 41; n++) begin
      @(posedge clk);
      #1;
      if (n == 41) start = 1'b0;
      if (done === 1'b1) begin
        if (done_cnt < 3) dc[done_cnt] = n;
        done_cnt++;
      end
    end
    chk("held_start_pulses", done_cnt, 3);
    chk("held_start_done1", dc[0], 13);
    chk("held_start_done2", dc[1], 27);
    chk("held_start_done3", dc[2], 41);
    repeat (3) @(posedge clk);
    #1;
    chk("held_start_idle_busy", int'(busy), 0);

    // Asynchronous reset while vector 10 is being driven.
    mode = 3;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    vec_at_rst  = int'({gate_a, gate_b});
    busy_at_rst = int'(busy);
    chk("pre_reset_vec", vec_at_rst, 2);
    chk("pre_reset_busy", busy_at_rst, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({gate_a, gate_b, busy, done, pass, err_count, fail_vec}), 0);
    repeat (2) @(negedge clk);
    chk("held_reset_outputs",
        int'({gate_a, gate_b, busy, done, pass, err_count, fail_vec}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_one(0, 0, 1, 0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
